// File: rtl/dmem_responder.sv
// Purpose: single-outstanding data-memory responder with byte-lane writes, range check
//          and optional lane parity (define DMEM_PARITY_EN to enable parity + par_inject).
// Latency: response WAIT+1 cycles after accept for reads, 1 cycle for writes / no-ops.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready is seen.
module dmem_responder #(
    parameter int w          = 32,
    parameter int h          = 8,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [w-1:0]     req_addr,
    input  logic [w/h-1:0]   req_wea,
    input  logic [w-1:0]     req_dina,
    input  logic             req_re,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [w-1:0]     rsp_rdat,
    output logic             rsp_err
`ifdef DMEM_PARITY_EN
    ,
    input  logic             par_inject
`endif
);

    localparam int         L      = w / h;
    localparam int         DEPTH  = 2 ** DEPTH_LOG2;
    localparam logic [3:0] WAIT_L = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic [w-1:0]          rdat_q, rdat_d;
    logic                  err_q, err_d;

    logic [w-1:0]          mem_q [DEPTH];

    logic                  accept;
    logic                  req_oor;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [w-1:0]          merge_w;
    logic                  merge_bad;
    logic                  stored_bad;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdat  = rdat_q;
    assign rsp_err   = err_q;

    assign accept  = req_valid && req_ready;
    // Any address bit at or above DEPTH_LOG2 means the word lies outside the array.
    assign req_oor = (req_addr >> DEPTH_LOG2) != '0;
    assign req_idx = req_addr[DEPTH_LOG2-1:0];

    // Post-write view of the addressed word, used when the read completes on the accept edge.
    always_comb begin
        merge_w = mem_q[req_idx];
        for (int l = 0; l < L; l++) begin
            if (req_wea[l]) begin
                merge_w[l*h +: h] = req_dina[l*h +: h];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [L-1:0] par_q [DEPTH];
    logic [L-1:0] new_par;
    logic [L-1:0] merge_par;

    function automatic logic par_bad(input logic [w-1:0] d, input logic [L-1:0] p);
        logic bad;
        bad = 1'b0;
        for (int l = 0; l < L; l++) begin
            bad = bad | ((^d[l*h +: h]) ^ p[l]);
        end
        return bad;
    endfunction

    // Even parity per written lane; par_inject flips it to emulate a storage fault.
    always_comb begin
        merge_par = par_q[req_idx];
        for (int l = 0; l < L; l++) begin
            new_par[l] = (^req_dina[l*h +: h]) ^ par_inject;
            if (req_wea[l]) begin
                merge_par[l] = new_par[l];
            end
        end
        merge_bad  = par_bad(merge_w, merge_par);
        stored_bad = par_bad(mem_q[idx_q], par_q[idx_q]);
    end

    // Parity store follows the data array lane by lane.
    always_ff @(posedge clk) begin
        if (rst_n && accept && !req_oor) begin
            for (int l = 0; l < L; l++) begin
                if (req_wea[l]) begin
                    par_q[req_idx][l] <= new_par[l];
                end
            end
        end
    end
`else
    assign merge_bad  = 1'b0;
    assign stored_bad = 1'b0;
`endif

    // Lane-masked write on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept && !req_oor) begin
            for (int l = 0; l < L; l++) begin
                if (req_wea[l]) begin
                    mem_q[req_idx][l*h +: h] <= req_dina[l*h +: h];
                end
            end
        end
    end

    // Next-state and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    idx_d = req_idx;
                    oor_d = req_oor;
                    if (req_re && (WAIT > 0)) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_L;
                    end else begin
                        state_d = S_RESP;
                        cnt_d   = 4'd0;
                        rdat_d  = (req_re && !req_oor) ? merge_w : '0;
                        err_d   = req_oor | (req_re && merge_bad);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                    rdat_d  = oor_q ? '0 : mem_q[idx_q];
                    err_d   = oor_q | stored_bad;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

endmodule
